// File: rtl/fxmem_arb.sv
// fxmem_arb: two-master arbiter for the single fxcpu16 memory port.
// Round-robin or fixed priority, lock for atomic pairs, access timeout.
module fxmem_arb #(
    parameter int TIMEOUT = 255,
    parameter bit PRIO_M0 = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [15:0] m0_wdata_i,
    input  logic        m0_lock_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [15:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [15:0] m1_wdata_i,
    input  logic        m1_lock_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [15:0] m1_rdata_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i,
    output logic        owner_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TMO_V = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          lock_hold;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          win;
    logic          lock_clr;
    logic          done;
    logic          tmo;
    logic          own_req;
    logic          own_lock;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        win      = 1'b0;
        lock_clr = 1'b0;
        done     = 1'b0;
        own_req  = owner_o ? m1_req_i : m0_req_i;
        own_lock = owner_o ? m1_lock_i : m0_lock_i;
        tmo      = (TIMEOUT != 0) && (cnt == TMO_V);
        unique case (state_q)
            IDLE: begin
                if (lock_hold) begin
                    // Locked: only the owner may go; release once it lets go.
                    if (own_req) begin
                        grant = 1'b1;
                        win   = owner_o;
                    end else if (!own_lock) begin
                        lock_clr = 1'b1;
                    end
                end else if (m0_req_i && m1_req_i) begin
                    grant = 1'b1;
                    win   = PRIO_M0 ? 1'b0 : ~owner_o;
                end else if (m0_req_i || m1_req_i) begin
                    grant = 1'b1;
                    win   = ~m0_req_i;
                end
                if (grant) state_d = WAIT;
            end
            WAIT: begin
                if (mem_ack_i || tmo) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            mem_stb_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            owner_o     <= 1'b1;
            lock_hold   <= 1'b0;
            cnt         <= '0;
            m0_ack_o    <= 1'b0;
            m0_err_o    <= 1'b0;
            m0_rdata_o  <= '0;
            m1_ack_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            m1_rdata_o  <= '0;
        end else begin
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;
            if (grant) begin
                owner_o     <= win;
                mem_stb_o   <= 1'b1;
                mem_we_o    <= win ? m1_we_i : m0_we_i;
                mem_addr_o  <= win ? m1_addr_i : m0_addr_i;
                mem_wdata_o <= win ? m1_wdata_i : m0_wdata_i;
                cnt         <= '0;
            end
            if (lock_clr) lock_hold <= 1'b0;
            if (state_q == WAIT && !done && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                mem_stb_o <= 1'b0;
                // An ack on the timeout cycle still counts as success.
                if (owner_o) begin
                    m1_ack_o <= 1'b1;
                    m1_err_o <= ~mem_ack_i;
                    if (!mem_ack_i) m1_rdata_o <= 16'hDEAD;
                    else if (!mem_we_o) m1_rdata_o <= mem_rdata_i;
                end else begin
                    m0_ack_o <= 1'b1;
                    m0_err_o <= ~mem_ack_i;
                    if (!mem_ack_i) m0_rdata_o <= 16'hDEAD;
                    else if (!mem_we_o) m0_rdata_o <= mem_rdata_i;
                end
            end
            if (state_q == RESP) lock_hold <= own_lock;
        end
    end

endmodule

// File: tb/tb_fxmem_arb.sv
// tb_fxmem_arb: randomized bench with transaction-level reference model.
// Second instance covers fixed-priority arbitration.
module tb_fxmem_arb;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        m0_req_i, m0_we_i, m0_lock_i;
    logic [31:0] m0_addr_i;
    logic [15:0] m0_wdata_i;
    logic        m0_ack_o, m0_err_o;
    logic [15:0] m0_rdata_o;
    logic        m1_req_i, m1_we_i, m1_lock_i;
    logic [31:0] m1_addr_i;
    logic [15:0] m1_wdata_i;
    logic        m1_ack_o, m1_err_o;
    logic [15:0] m1_rdata_o;
    logic        mem_stb_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o;
    logic [15:0] mem_wdata_o, mem_rdata_i;
    logic        owner_o;

    logic        fp_req0, fp_req1;
    logic        fp_ack0, fp_err0, fp_ack1, fp_err1;
    logic [15:0] fp_rd0, fp_rd1;
    logic        fp_stb, fp_we, fp_owner;
    logic [31:0] fp_addr;
    logic [15:0] fp_wdata;

    always #5 clk_i = ~clk_i;

    fxmem_arb #(.TIMEOUT(TMO), .PRIO_M0(1'b0)) u_rr (
        .clk_i(clk_i), .reset(reset),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
        .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .owner_o(owner_o)
    );

    // Zero-wait memory: acks in the first strobe cycle.
    fxmem_arb #(.TIMEOUT(TMO), .PRIO_M0(1'b1)) u_fp (
        .clk_i(clk_i), .reset(reset),
        .m0_req_i(fp_req0), .m0_we_i(1'b0), .m0_addr_i(32'h0000_0010),
        .m0_wdata_i(16'h0), .m0_lock_i(1'b0),
        .m0_ack_o(fp_ack0), .m0_err_o(fp_err0), .m0_rdata_o(fp_rd0),
        .m1_req_i(fp_req1), .m1_we_i(1'b0), .m1_addr_i(32'h0000_0020),
        .m1_wdata_i(16'h0), .m1_lock_i(1'b0),
        .m1_ack_o(fp_ack1), .m1_err_o(fp_err1), .m1_rdata_o(fp_rd1),
        .mem_stb_o(fp_stb), .mem_we_o(fp_we), .mem_addr_o(fp_addr),
        .mem_wdata_o(fp_wdata), .mem_ack_i(fp_stb),
        .mem_rdata_i(16'h5A5A), .owner_o(fp_owner)
    );

    int checks = 0;
    int errors = 0;

    // Pending transaction per master
    logic        pv[2], pwe[2], plock[2];
    logic [31:0] pa[2];
    logic [15:0] pd[2];

    // Reference model state
    int          m_own;
    bit          m_lock;
    logic [15:0] rd[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own  = 1;
        m_lock = 1'b0;
        rd[0]  = '0;
        rd[1]  = '0;
    endtask

    task automatic new_xact(input int n, input bit lockable);
        pv[n]    = 1'b1;
        pwe[n]   = 1'($urandom_range(0, 1));
        pa[n]    = $urandom & 32'hFFFF_FFFE;
        pd[n]    = 16'($urandom);
        plock[n] = lockable && ($urandom_range(0, 3) == 0);
    endtask

    task automatic drive_masters();
        m0_req_i   = pv[0];
        m0_we_i    = pwe[0];
        m0_addr_i  = pa[0];
        m0_wdata_i = pd[0];
        m0_lock_i  = pv[0] & plock[0];
        m1_req_i   = pv[1];
        m1_we_i    = pwe[1];
        m1_addr_i  = pa[1];
        m1_wdata_i = pd[1];
        m1_lock_i  = pv[1] & plock[1];
    endtask

    // Who should win this IDLE cycle (-1: nobody)
    task automatic arbitrate(output int g);
        g = -1;
        if (m_lock) begin
            if (pv[m_own]) g = m_own;
            else m_lock = 1'b0;
        end else if (pv[0] && pv[1]) begin
            g = 1 - m_own;
        end else if (pv[0]) begin
            g = 0;
        end else if (pv[1]) begin
            g = 1;
        end
    endtask

    // One IDLE cycle, plus the whole access if someone is granted.
    // Memory acks in wait cycle w (0 = first strobe cycle).
    task automatic run_slot(input int w, input logic [15:0] data,
                            output int g);
        bit ok;
        ok = 1'b0;
        drive_masters();
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = 16'($urandom);
        arbitrate(g);
        @(negedge clk_i);
        if (g < 0) begin
            chk("idle_stb", mem_stb_o, 0);
            chk("idle_ack", {m1_ack_o, m0_ack_o}, 0);
            return;
        end
        chk("grant_stb", mem_stb_o, 1);
        chk("grant_owner", owner_o, g);
        chk("grant_addr", mem_addr_o, pa[g]);
        chk("grant_we", mem_we_o, pwe[g]);
        chk("grant_wdata", mem_wdata_o, pd[g]);
        m_own = g;
        for (int k = 0; k <= TMO; k++) begin
            mem_ack_i   = (k == w);
            mem_rdata_i = data;
            if (g == 0) begin
                m0_addr_i  = $urandom;
                m0_wdata_i = 16'($urandom);
            end else begin
                m1_addr_i  = $urandom;
                m1_wdata_i = 16'($urandom);
            end
            @(negedge clk_i);
            if (k == w) begin
                ok = 1'b1;
                break;
            end
            if (k == TMO) break;
            chk("wait_stb", mem_stb_o, 1);
            chk("wait_ack", {m1_ack_o, m0_ack_o}, 0);
            chk("wait_addr", mem_addr_o, pa[g]);
        end
        if (!ok) rd[g] = 16'hDEAD;
        else if (!pwe[g]) rd[g] = data;
        chk("resp_stb", mem_stb_o, 0);
        chk("resp_ack", {m1_ack_o, m0_ack_o}, (g == 1) ? 2'b10 : 2'b01);
        chk("resp_err", {m1_err_o, m0_err_o},
            ok ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01));
        chk("resp_rd0", m0_rdata_o, rd[0]);
        chk("resp_rd1", m1_rdata_o, rd[1]);
        m_lock      = pv[g] & plock[g];
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = 16'($urandom);
        @(negedge clk_i);
        chk("post_ack", {m1_ack_o, m0_ack_o}, 0);
        chk("post_stb", mem_stb_o, 0);
        pv[g] = 1'b0;
    endtask

    initial begin
        int g;
        int n0, n1, cyc;
        bit seen;
        reset     = 1'b1;
        pv[0]     = 1'b0;
        pv[1]     = 1'b0;
        plock[0]  = 1'b0;
        plock[1]  = 1'b0;
        pwe[0]    = 1'b0;
        pwe[1]    = 1'b0;
        pa[0]     = '0;
        pa[1]     = '0;
        pd[0]     = '0;
        pd[1]     = '0;
        fp_req0   = 1'b0;
        fp_req1   = 1'b0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        drive_masters();
        model_reset();
        repeat (2) @(negedge clk_i);
        reset = 1'b0;
        @(negedge clk_i);
        chk("rst_stb", mem_stb_o, 0);
        chk("rst_owner", owner_o, 1);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_ack", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 0);
        chk("rst_rd0", m0_rdata_o, 0);
        chk("rst_rd1", m1_rdata_o, 0);

        // Single read, two wait cycles
        pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 32'h4000_0000; plock[0] = 1'b0;
        run_slot(2, 16'h1234, g);
        chk("single_grant", g, 0);
        chk("single_rdata", m0_rdata_o, 16'h1234);

        // Round-robin, both continuously requesting
        for (int i = 0; i < 4; i++) begin
            if (!pv[0]) new_xact(0, 1'b0);
            if (!pv[1]) new_xact(1, 1'b0);
            run_slot(0, 16'($urandom), g);
            chk("rr_grant", g, (i % 2 == 0) ? 1 : 0);
        end

        // Lock pair from m1 while m0 keeps requesting
        new_xact(0, 1'b0);
        pv[1] = 1'b1; pwe[1] = 1'b1; pa[1] = 32'h100; pd[1] = 16'hA5A5;
        plock[1] = 1'b1;
        run_slot(1, 16'h0, g);
        chk("lock_first", g, 1);
        pv[1] = 1'b1; pwe[1] = 1'b1; pa[1] = 32'h102; pd[1] = 16'h5A5A;
        plock[1] = 1'b0;
        run_slot(0, 16'h0, g);
        chk("lock_second", g, 1);
        run_slot(0, 16'h0, g);
        chk("lock_then_m0", g, 0);

        // Timeout, then a normal access
        pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 32'h200; plock[0] = 1'b0;
        run_slot(100, 16'h0, g);
        chk("tmo_rdata", m0_rdata_o, 16'hDEAD);
        pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 32'h204;
        run_slot(1, 16'hBEEF, g);
        chk("tmo_next", m0_rdata_o, 16'hBEEF);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && $urandom_range(0, 2) != 0) new_xact(n, 1'b1);
            end
            run_slot($urandom_range(0, 6), 16'($urandom), g);
        end

        // Reset in the middle of an access
        new_xact(0, 1'b0);
        new_xact(1, 1'b0);
        drive_masters();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("mid_pre_stb", mem_stb_o, 1);
        @(posedge clk_i);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_stb", mem_stb_o, 0);
        chk("mid_ack", {m1_ack_o, m0_ack_o}, 0);
        model_reset();
        @(negedge clk_i);
        chk("mid_hold_ack", {m1_ack_o, m0_ack_o}, 0);
        reset = 1'b0;
        run_slot(0, 16'h0, g);
        chk("mid_first", g, 0);

        // Fixed priority: m1 starved until m0 drops
        fp_req0 = 1'b1;
        fp_req1 = 1'b1;
        n0  = 0;
        n1  = 0;
        cyc = -1;
        for (int c = 0; c < 40 && n0 < 4; c++) begin
            @(negedge clk_i);
            if (fp_ack0) n0++;
            if (fp_ack1) n1++;
            if (n0 == 4) cyc = c;
        end
        chk("fp_m0_cnt", n0, 4);
        chk("fp_m1_starved", n1, 0);
        chk("fp_tput", cyc, 10);
        chk("fp_rdata", fp_rd0, 16'h5A5A);
        fp_req0 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            if (fp_ack1) seen = 1'b1;
        end
        chk("fp_m1_after", seen, 1);
        chk("fp_owner", fp_owner, 1);
        fp_req1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
